approx_eval_sequencer: RTL and testbench

Exhaustive-stimulus controller for comparing an exact small combinational benchmark circuit with an approximate variant of it. It drives every N_IN-bit input vector into both circuits and waits a programmable settle time. It then samples and compares the two output buses and accumulates error statistics: erroneous vectors, flipped output bits, and the first failing vector. It sits beside the exact/approximate circuit pair in the error-characterisation harness and is started and read by the surrounding test logic.

---
 rtl/approx_eval_sequencer.sv | 161 ++++++++++++++++
 tb/tb_approx_eval_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/approx_eval_sequencer.sv
// Exhaustive sweep controller: drives every input vector into an exact/approximate
// circuit pair, waits SETTLE cycles, then compares outputs and accumulates error stats.
module approx_eval_sequencer #(
    parameter int unsigned N_IN   = 5,
    parameter int unsigned N_OUT  = 2,
    parameter int unsigned SETTLE = 1,
    parameter int unsigned BW     = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [N_OUT-1:0]  exact_i,
    input  logic [N_OUT-1:0]  approx_i,
    output logic [N_IN-1:0]   vec_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [N_IN:0]     err_cnt_o,
    output logic [BW-1:0]     biterr_cnt_o,
    output logic [N_IN-1:0]   first_err_vec_o,
    output logic              first_err_valid_o
);

    localparam int unsigned SW = 4;
    localparam int unsigned EW = N_IN + 1;
    localparam logic [N_IN-1:0] VEC_LAST    = '1;
    localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SAMPLE,
        ST_FINISH
    } state_e;

    state_e            state_q, state_d;
    logic [N_IN-1:0]   vec_q, vec_d;
    logic [SW-1:0]     settle_q, settle_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [EW-1:0]     err_q, err_d;
    logic [BW-1:0]     biterr_q, biterr_d;
    logic [N_IN-1:0]   first_vec_q, first_vec_d;
    logic              first_valid_q, first_valid_d;

    logic [N_OUT-1:0]  diff_c;
    logic [BW-1:0]     popcnt_c;
    logic              mismatch_c;

    // Mismatch detection is combinational straight into the counters
    always_comb begin
        diff_c   = exact_i ^ approx_i;
        popcnt_c = '0;
        for (int i = 0; i < N_OUT; i++) begin
            popcnt_c = popcnt_c + BW'(diff_c[i]);
        end
        mismatch_c = |diff_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            vec_q         <= '0;
            settle_q      <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= '0;
            biterr_q      <= '0;
            first_vec_q   <= '0;
            first_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            vec_q         <= vec_d;
            settle_q      <= settle_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
            biterr_q      <= biterr_d;
            first_vec_q   <= first_vec_d;
            first_valid_q <= first_valid_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        vec_d         = vec_q;
        settle_d      = settle_q;
        err_d         = err_q;
        biterr_d      = biterr_q;
        first_vec_d   = first_vec_q;
        first_valid_d = first_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d       = ST_APPLY;
                    vec_d         = '0;
                    settle_d      = '0;
                    err_d         = '0;
                    biterr_d      = '0;
                    first_vec_d   = '0;
                    first_valid_d = 1'b0;
                end
            end
            ST_APPLY: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                    vec_d   = '0;
                end else begin
                    settle_d = settle_q + SW'(1);
                    if (settle_q == SETTLE_LAST) begin
                        state_d = ST_SAMPLE;
                    end
                end
            end
            ST_SAMPLE: begin
                // Abort wins over the sample: the pending compare is dropped
                if (abort_i) begin
                    state_d = ST_IDLE;
                    vec_d   = '0;
                end else begin
                    if (mismatch_c) begin
                        err_d    = err_q + EW'(1);
                        biterr_d = biterr_q + popcnt_c;
                        if (!first_valid_q) begin
                            first_vec_d   = vec_q;
                            first_valid_d = 1'b1;
                        end
                    end
                    if (vec_q == VEC_LAST) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d  = ST_APPLY;
                        vec_d    = vec_q + N_IN'(1);
                        settle_d = '0;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
                vec_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                vec_d   = '0;
            end
        endcase

        busy_d = (state_d == ST_APPLY) || (state_d == ST_SAMPLE);
        done_d = (state_d == ST_FINISH);
    end

    assign vec_o             = vec_q;
    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign err_cnt_o         = err_q;
    assign biterr_cnt_o      = biterr_q;
    assign first_err_vec_o   = first_vec_q;
    assign first_err_valid_o = first_valid_q;

endmodule

// File: tb/tb_approx_eval_sequencer.sv
// Directed bench for approx_eval_sequencer: default instance plus a SETTLE=3 instance.
module tb_approx_eval_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start1 = 1'b0, abort1 = 1'b0;
    logic [1:0] mask1, exact1, approx1;
    logic [4:0] vec1, first1;
    logic       busy1, done1, valid1;
    logic [5:0] err1;
    logic [6:0] bit1;
    int         mode1 = 0;

    logic       start3 = 1'b0, abort3 = 1'b0, glitch3 = 1'b0;
    logic [1:0] mask3, exact3, approx3;
    logic [4:0] vec3, first3;
    logic       busy3, done3, valid3;
    logic [5:0] err3;
    logic [6:0] bit3;

    int n_chk = 0;
    int n_fail = 0;

    function automatic logic [1:0] f_exact(input logic [4:0] v);
        return v[1:0] ^ v[3:2] ^ {1'b0, v[4]};
    endfunction

    assign exact1  = f_exact(vec1);
    assign approx1 = exact1 ^ mask1;
    assign exact3  = f_exact(vec3);
    assign approx3 = exact3 ^ mask3;

    // Error injection pattern for the default instance
    always_comb begin
        mask1 = 2'b00;
        case (mode1)
            1: mask1 = 2'b01;
            2: mask1 = (vec1 == 5'd19) ? 2'b11 : ((vec1 == 5'd27) ? 2'b10 : 2'b00);
            default: mask1 = 2'b00;
        endcase
    end

    always_comb begin
        if (vec3 == 5'd5 || vec3 == 5'd6) mask3 = 2'b01;
        else if (glitch3)                 mask3 = 2'b11;
        else                              mask3 = 2'b00;
    end

    approx_eval_sequencer #(.N_IN(5), .N_OUT(2), .SETTLE(1), .BW(7)) dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start1), .abort_i(abort1),
        .exact_i(exact1), .approx_i(approx1), .vec_o(vec1), .busy_o(busy1),
        .done_o(done1), .err_cnt_o(err1), .biterr_cnt_o(bit1),
        .first_err_vec_o(first1), .first_err_valid_o(valid1)
    );

    approx_eval_sequencer #(.N_IN(5), .N_OUT(2), .SETTLE(3), .BW(7)) dut3 (
        .clk(clk), .rst_n(rst_n), .start_i(start3), .abort_i(abort3),
        .exact_i(exact3), .approx_i(approx3), .vec_o(vec3), .busy_o(busy3),
        .done_o(done3), .err_cnt_o(err3), .biterr_cnt_o(bit3),
        .first_err_vec_o(first3), .first_err_valid_o(valid3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    // Full sweep on the default instance; cycle c lies between edge c and edge c+1
    task automatic sweep1(output int done_cyc, output int walk_err, output logic busy_at_done);
        done_cyc     = -1;
        walk_err     = 0;
        busy_at_done = 1'b1;
        @(negedge clk);
        start1 = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (c == 0) start1 = 1'b0;
            if (c < 64 && (vec1 !== 5'(c / 2) || busy1 !== 1'b1)) walk_err++;
            if (done1 === 1'b1) begin
                done_cyc     = c;
                busy_at_done = busy1;
                break;
            end
        end
    endtask

    int   dc, we, dc3;
    logic bd, done_seen;

    initial begin
        repeat (2) @(negedge clk);
        check("rst_vec",   32'(vec1),   0);
        check("rst_busy",  32'(busy1),  0);
        check("rst_done",  32'(done1),  0);
        check("rst_err",   32'(err1),   0);
        check("rst_bit",   32'(bit1),   0);
        check("rst_valid", 32'(valid1), 0);
        rst_n = 1'b1;

        // Matching circuits: no errors, DONE in cycle 64
        mode1 = 0;
        sweep1(dc, we, bd);
        check("t1_done_cyc",  32'(dc),  64);
        check("t1_walk",      32'(we),  0);
        check("t1_busy_done", 32'(bd),  0);
        check("t1_fin_vec",   32'(vec1), 31);
        check("t1_err",       32'(err1), 0);
        check("t1_bit",       32'(bit1), 0);
        check("t1_valid",     32'(valid1), 0);

        // Bit 0 flipped everywhere; started back-to-back right after DONE
        mode1 = 1;
        sweep1(dc, we, bd);
        check("t2_done_cyc", 32'(dc),     64);
        check("t2_err",      32'(err1),   32);
        check("t2_bit",      32'(bit1),   32);
        check("t2_first",    32'(first1), 0);
        check("t2_valid",    32'(valid1), 1);

        // Two-bit error at 19, one-bit error at 27
        mode1 = 2;
        sweep1(dc, we, bd);
        check("t3_done_cyc", 32'(dc),     64);
        check("t3_walk",     32'(we),     0);
        check("t3_err",      32'(err1),   2);
        check("t3_bit",      32'(bit1),   3);
        check("t3_first",    32'(first1), 19);
        check("t3_valid",    32'(valid1), 1);
        repeat (4) @(negedge clk);
        check("t3_hold_err", 32'(err1),   2);
        check("t3_hold_vec", 32'(vec1),   0);

        // SETTLE=3: APPLY-phase glitches on other vectors must not count
        dc3 = -1;
        @(negedge clk);
        start3 = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (c == 0) start3 = 1'b0;
            glitch3 = ((c % 4) != 3);
            if (done3 === 1'b1) begin
                dc3 = c;
                break;
            end
        end
        glitch3 = 1'b0;
        check("t4_done_cyc", 32'(dc3),    128);
        check("t4_err",      32'(err3),   2);
        check("t4_bit",      32'(bit3),   2);
        check("t4_first",    32'(first3), 5);

        // Abort after 10 cycles; a START while busy is ignored
        mode1 = 1;
        done_seen = 1'b0;
        @(negedge clk);
        start1 = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done1 === 1'b1) done_seen = 1'b1;
            if (c == 0)  start1 = 1'b0;
            if (c == 3)  start1 = 1'b1;
            if (c == 4)  start1 = 1'b0;
            if (c == 10) abort1 = 1'b1;
            if (c == 11) abort1 = 1'b0;
        end
        check("t5_busy", 32'(busy1), 0);
        check("t5_vec",  32'(vec1),  0);
        check("t5_err",  32'(err1),  5);
        check("t5_bit",  32'(bit1),  5);
        repeat (3) begin
            @(negedge clk);
            if (done1 === 1'b1) done_seen = 1'b1;
        end
        check("t5_no_done",  32'(done_seen), 0);
        check("t5_idle",     32'(busy1),     0);

        // New START clears counters
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("t6_clr_err",   32'(err1),   0);
        check("t6_clr_valid", 32'(valid1), 0);
        check("t6_busy",      32'(busy1),  1);
        repeat (7) @(negedge clk);

        // Asynchronous reset between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        check("t7_vec",   32'(vec1),   0);
        check("t7_busy",  32'(busy1),  0);
        check("t7_err",   32'(err1),   0);
        check("t7_bit",   32'(bit1),   0);
        check("t7_valid", 32'(valid1), 0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done1 === 1'b1 || busy1 === 1'b1) done_seen = 1'b1;
        end
        check("t7_quiet", 32'(done_seen), 0);
        check("t7_vec_after", 32'(vec1), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
